// File: rtl/mdu_issue_ctrl.sv
// mdu_issue_ctrl
//   E-stage issue controller in front of the multiply/divide unit (MDU).
//   Decodes the E-stage MD-class op into the MDU control strobes, keeps a
//   shadow busy countdown that matches the MDU latency, and raises the
//   D-stage stall for MD-class instructions while the MDU is busy. A sticky
//   protocol-error flag and a saturating stall-cycle counter are kept for
//   verification.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high reset
//   d_valid    in   D-stage holds a real instruction
//   d_op       in   D-stage MD class code (0 none, 1 mult, 2 multu, 3 div,
//                   4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none)
//   e_valid    in   E-stage holds a real instruction
//   e_op       in   E-stage MD class code, same encoding as d_op
//   flush_e    in   E-stage instruction is squashed this cycle
//   start      out  MDU Start
//   mdu_op     out  MDU op: 0 mult, 1 multu, 2 div, 3 divu
//   hi_write   out  MDU HI write strobe (mthi)
//   lo_write   out  MDU LO write strobe (mtlo)
//   hi_read    out  MDU HI read select (mfhi)
//   lo_read    out  MDU LO read select (mflo)
//   busy       out  shadow of MDU Busy
//   stall_d    out  freeze PC and D, bubble into E
//   proto_err  out  sticky protocol-error flag
//   stall_cnt  out  saturating count of MD stall cycles

module mdu_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [3:0]       d_op,
    input  logic             e_valid,
    input  logic [3:0]       e_op,
    input  logic             flush_e,
    output logic             start,
    output logic [3:0]       mdu_op,
    output logic             hi_write,
    output logic             lo_write,
    output logic             hi_read,
    output logic             lo_read,
    output logic             busy,
    output logic             stall_d,
    output logic             proto_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_t;

    localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
    localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

    state_t     state;
    state_t     state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;

    logic       iss;
    logic       e_mul;
    logic       e_div;
    logic       e_md;
    logic       d_md;
    logic [2:0] strobe_sum;
    logic       multi_strobe;
    logic       missed_stall;

    // Op-class decode for both stages.
    assign iss   = e_valid && !flush_e;
    assign e_mul = (e_op == 4'd1) || (e_op == 4'd2);
    assign e_div = (e_op == 4'd3) || (e_op == 4'd4);
    assign e_md  = (e_op != 4'd0) && (e_op <= 4'd8);
    assign d_md  = (d_op != 4'd0) && (d_op <= 4'd8);

    // Strobes are purely combinational from E; they keep following the
    // inputs during reset because the MDU itself gives reset priority.
    assign start    = iss && (e_mul || e_div);
    assign mdu_op   = (e_mul || e_div) ? (e_op - 4'd1) : 4'd0;
    assign hi_write = iss && (e_op == 4'd7);
    assign lo_write = iss && (e_op == 4'd8);
    assign hi_read  = iss && (e_op == 4'd5);
    assign lo_read  = iss && (e_op == 4'd6);

    // Busy includes the start cycle itself, so a dependent MD op in D is
    // held from the very cycle its producer issues.
    assign busy    = start || (cnt != 4'd0);
    assign stall_d = d_valid && d_md && busy;

    assign strobe_sum   = 3'(start) + 3'(hi_write) + 3'(lo_write)
                        + 3'(hi_read) + 3'(lo_read);
    assign multi_strobe = (strobe_sum > 3'd1);
    // An MD op reaching E with the countdown still running means the
    // D-stage stall was not honoured upstream.
    assign missed_stall = iss && e_md && (cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // A new start always reloads the countdown, even mid-operation; the
    // in-flight operation is left to the MDU to commit.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (start) begin
            if (e_mul) begin
                state_next = MUL;
                cnt_next   = MUL_LAT_C;
            end else begin
                state_next = DIV;
                cnt_next   = DIV_LAT_C;
            end
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
                MUL, DIV: begin
                    if (cnt <= 4'd1) begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt - 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (missed_stall || multi_strobe) begin
                proto_err <= 1'b1;
            end
            if (stall_d && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
